bc_sched: RTL

BC_SCHED -- requirements
Module: bc_sched

---
 rtl/mfa_pkg.sv | 35 +++
 rtl/occ_counter.sv | 51 +++++
 rtl/bc_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mfa_pkg.sv
// Shared constants and types for the box-count scheduler: FSM encoding,
// RAM address width derivation and the per-level write boundaries.
package mfa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } bc_state_t;

    // RAM address width: the level-0 image (4^box_idx words) plus every
    // coarser level fits in 2*box_idx+1 bits.
    function automatic int f_addr_w(input int box_idx);
        return 2 * box_idx + 1;
    endfunction

    // Cumulative write count after levels 1..k have been produced:
    // sum over j=1..k of 4^(box_idx-j). Level k owns write indices
    // [f_level_bound(k-1), f_level_bound(k)).
    function automatic int f_level_bound(input int box_idx, input int k);
        int acc;
        acc = 0;
        for (int j = 1; j <= k; j++) begin
            acc = acc + (1 << (2 * (box_idx - j)));
        end
        return acc;
    endfunction

    // Total number of square-generator writes in one reduction run.
    function automatic int f_nwr(input int box_idx);
        return f_level_bound(box_idx, box_idx);
    endfunction

endpackage

// File: rtl/occ_counter.sv
// Per-level occupied-box counter. Each write index is mapped to its level
// by the cumulative boundaries; a nonzero write bumps that level's count.
// Counts clear on a new run and hold whenever inc is low.
module occ_counter
    import mfa_pkg::*;
#(
    parameter  int BOX_IDX = 3,
    localparam int ADDR_W  = f_addr_w(BOX_IDX)
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        clr,
    input  logic                        inc,
    input  logic                        nz,
    input  logic [ADDR_W-1:0]           idx,
    output logic [BOX_IDX*ADDR_W-1:0]   occ_cnt
);

    logic [BOX_IDX-1:0] below_s;
    logic [BOX_IDX-1:0] hit_s;

    for (genvar g = 0; g < BOX_IDX; g++) begin : g_lvl
        localparam int HI = f_level_bound(BOX_IDX, g + 1);

        logic [ADDR_W-1:0] cnt_r;

        assign below_s[g] = (idx < ADDR_W'(HI));

        if (g == 0) begin : g_first
            assign hit_s[g] = below_s[g];
        end else begin : g_rest
            assign hit_s[g] = below_s[g] & ~below_s[g-1];
        end

        // Level g+1 nonzero-box counter with clear and hold.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                cnt_r <= '0;
            end else if (clr) begin
                cnt_r <= '0;
            end else if (inc && nz && hit_s[g]) begin
                cnt_r <= cnt_r + ADDR_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end

        assign occ_cnt[g*ADDR_W +: ADDR_W] = cnt_r;
    end

endmodule

// File: rtl/bc_sched.sv
// Box-count reduction scheduler. Arbitrates the BC RAM port between the
// host and the external square generator, sequences one reduction run,
// counts occupied boxes per level and guards the run with a watchdog.
module bc_sched
    import mfa_pkg::*;
#(
    parameter  int BOX_IDX  = 3,
    parameter  int DATA_LEN = 8,
    localparam int ADDR_W   = f_addr_w(BOX_IDX),
    localparam int NWR      = f_nwr(BOX_IDX)
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    input  logic                        host_req,
    output logic                        host_gnt,
    input  logic                        host_wen,
    input  logic [ADDR_W-1:0]           host_addr,
    input  logic [DATA_LEN-1:0]         host_wdata,
    output logic                        sqg_BC_mode,
    input  logic                        sqg_wen,
    input  logic [DATA_LEN-1:0]         sqg_y,
    input  logic [ADDR_W-1:0]           sqg_rd_addr,
    input  logic [ADDR_W-1:0]           sqg_wr_addr,
    output logic                        ram_wen,
    output logic [ADDR_W-1:0]           ram_wr_addr,
    output logic [ADDR_W-1:0]           ram_rd_addr,
    output logic [DATA_LEN-1:0]         ram_wdata,
    output logic [BOX_IDX*ADDR_W-1:0]   occ_cnt
);

    localparam int WD_W = ADDR_W + 1;

    bc_state_t          state_r;
    bc_state_t          state_nxt_s;
    logic [ADDR_W-1:0]  wr_cnt_r;
    logic [WD_W-1:0]    wdog_r;
    logic               done_r;

    logic               run_s;
    logic               start_acc_s;
    logic               wr_ev_s;
    logic               last_wr_s;
    logic               wdog_full_s;

    assign run_s       = (state_r == ST_RUN);
    assign start_acc_s = start & ~host_req &
                         ((state_r == ST_IDLE) | (state_r == ST_DONE));
    assign wr_ev_s     = run_s & sqg_wen;
    assign last_wr_s   = (wr_cnt_r == ADDR_W'(NWR - 1));
    assign wdog_full_s = &wdog_r;

    assign busy        = run_s;
    assign err         = (state_r == ST_ERR);
    assign done        = done_r;
    assign sqg_BC_mode = ~run_s;
    assign host_gnt    = host_req & ~run_s;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a final write outranks a simultaneous watchdog expiry.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_acc_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (sqg_wen && last_wr_s) begin
                    state_nxt_s = ST_DONE;
                end else if (!sqg_wen && wdog_full_s) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Write counter: index of the next square-generator write in this run.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_cnt_r <= '0;
        end else if (start_acc_s) begin
            wr_cnt_r <= '0;
        end else if (wr_ev_s) begin
            wr_cnt_r <= wr_cnt_r + ADDR_W'(1);
        end else begin
            wr_cnt_r <= wr_cnt_r;
        end
    end

    // Watchdog: cycles in RUN since the last write (or since run entry).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wdog_r <= '0;
        end else if (start_acc_s) begin
            wdog_r <= '0;
        end else if (run_s) begin
            if (sqg_wen) begin
                wdog_r <= '0;
            end else begin
                wdog_r <= wdog_r + WD_W'(1);
            end
        end else begin
            wdog_r <= wdog_r;
        end
    end

    // Completion pulse, high only in the first DONE cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            done_r <= 1'b0;
        end else begin
            done_r <= wr_ev_s & last_wr_s;
        end
    end

    // RAM port mux: square generator in RUN, host when granted, else idle.
    always_comb begin
        ram_wen     = 1'b0;
        ram_wr_addr = host_addr;
        ram_rd_addr = host_addr;
        ram_wdata   = host_wdata;
        if (run_s) begin
            ram_wen     = sqg_wen;
            ram_wr_addr = sqg_wr_addr;
            ram_rd_addr = sqg_rd_addr;
            ram_wdata   = sqg_y;
        end else if (host_gnt) begin
            ram_wen     = host_wen;
            ram_wr_addr = host_addr;
            ram_rd_addr = host_addr;
            ram_wdata   = host_wdata;
        end else begin
            ram_wen     = 1'b0;
        end
    end

    occ_counter #(
        .BOX_IDX (BOX_IDX)
    ) u_occ (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clr     (start_acc_s),
        .inc     (wr_ev_s),
        .nz      (sqg_y != '0),
        .idx     (wr_cnt_r),
        .occ_cnt (occ_cnt)
    );

endmodule
